// File: rtl/mpu_seq_pkg.sv
// Shared encodings for the MPU6050 sample sequencer: I2C byte-engine commands,
// sequencer FSM states and the MPU register map entries used by the sequencer.
package mpu_seq_pkg;

    typedef enum logic [2:0] {
        CMD_START     = 3'd0,
        CMD_WRITE     = 3'd1,
        CMD_READ_ACK  = 3'd2,
        CMD_READ_NACK = 3'd3,
        CMD_STOP      = 3'd4
    } i2c_cmd_t;

    // INIT_ISSUE must stay first so the reset encoding is zero
    typedef enum logic [2:0] {
        INIT_ISSUE,
        INIT_WAIT,
        IDLE,
        RD_ISSUE,
        RD_WAIT,
        ABORT_STOP,
        ABORT_WAIT,
        SEND
    } seq_state_t;

    localparam logic [7:0] PWR_MGMT_1   = 8'h6B;
    localparam logic [7:0] ACCEL_XOUT_H = 8'h3B;
    localparam int unsigned MAX_BURST   = 16;

    function automatic logic is_read_cmd(input i2c_cmd_t c);
        return (c == CMD_READ_ACK) || (c == CMD_READ_NACK);
    endfunction

endpackage

// File: rtl/seq_period_timer.sv
// Free-running 0..PERIOD-1 counter; tick is a combinational one-cycle pulse at the
// terminal count. No backpressure: ticks are never held or queued.
module seq_period_timer #(
    parameter int unsigned PERIOD = 2500000
) (
    input  logic dev_clk,
    input  logic rst,
    output logic tick
);

    localparam int unsigned CW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam logic [CW-1:0] LAST = CW'(PERIOD - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge dev_clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tick = (cnt == LAST);

endmodule

// File: rtl/mpu_sample_sequencer.sv
// Wakes the MPU6050, then per tick burst-reads BURST_LEN bytes and frames them to the UART.
// One I2C command outstanding; cmd/tx outputs are registered and held until handshake.
module mpu_sample_sequencer
    import mpu_seq_pkg::*;
#(
    parameter logic [6:0]  SLAVE_ADDR    = 7'h68,
    parameter logic [7:0]  PWR_REG       = PWR_MGMT_1,
    parameter logic [7:0]  PWR_VAL       = 8'h00,
    parameter logic [7:0]  START_REG     = ACCEL_XOUT_H,
    parameter int unsigned BURST_LEN     = 6,
    parameter int unsigned SAMPLE_PERIOD = 2500000,
    parameter logic [7:0]  FRAME_HDR     = 8'hA5
) (
    input  logic        dev_clk,
    input  logic        rst,
    input  logic        enable,
    output logic        i2c_cmd_valid,
    input  logic        i2c_cmd_ready,
    output logic [2:0]  i2c_cmd,
    output logic [7:0]  i2c_wdata,
    input  logic        i2c_rsp_valid,
    input  logic [7:0]  i2c_rsp_data,
    input  logic        i2c_rsp_nack,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    input  logic        tx_ready,
    output logic        init_done,
    output logic        err_nack,
    output logic        overrun,
    output logic [15:0] sample_count
);

    // READ list: 0 START, 1 addr+W, 2 START_REG, 3 START, 4 addr+R, then reads, then STOP
    localparam logic [4:0] NACK_STEP = 5'(BURST_LEN + 4);
    localparam logic [4:0] LAST_BYTE = 5'(BURST_LEN);

    seq_state_t state;
    i2c_cmd_t   cur_cmd;
    i2c_cmd_t   nxt_cmd;
    logic [7:0] nxt_wdata;
    logic [4:0] step;
    logic [3:0] rd_idx;
    logic [4:0] tx_idx;
    logic [7:0] burst_buf [MAX_BURST];
    logic       tick;

    seq_period_timer #(
        .PERIOD (SAMPLE_PERIOD)
    ) u_timer (
        .dev_clk (dev_clk),
        .rst     (rst),
        .tick    (tick)
    );

    assign i2c_cmd = cur_cmd;

    // Command list decode; ABORT_STOP falls through to the STOP default
    always_comb begin
        nxt_cmd   = CMD_STOP;
        nxt_wdata = 8'h00;
        if (state == INIT_ISSUE) begin
            case (step)
                5'd0: nxt_cmd = CMD_START;
                5'd1: begin nxt_cmd = CMD_WRITE; nxt_wdata = {SLAVE_ADDR, 1'b0}; end
                5'd2: begin nxt_cmd = CMD_WRITE; nxt_wdata = PWR_REG; end
                5'd3: begin nxt_cmd = CMD_WRITE; nxt_wdata = PWR_VAL; end
                default: nxt_cmd = CMD_STOP;
            endcase
        end else if (state == RD_ISSUE) begin
            case (step)
                5'd0: nxt_cmd = CMD_START;
                5'd1: begin nxt_cmd = CMD_WRITE; nxt_wdata = {SLAVE_ADDR, 1'b0}; end
                5'd2: begin nxt_cmd = CMD_WRITE; nxt_wdata = START_REG; end
                5'd3: nxt_cmd = CMD_START;
                5'd4: begin nxt_cmd = CMD_WRITE; nxt_wdata = {SLAVE_ADDR, 1'b1}; end
                default: begin
                    if (step < NACK_STEP) begin
                        nxt_cmd = CMD_READ_ACK;
                    end else if (step == NACK_STEP) begin
                        nxt_cmd = CMD_READ_NACK;
                    end else begin
                        nxt_cmd = CMD_STOP;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge dev_clk or posedge rst) begin
        if (rst) begin
            state         <= INIT_ISSUE;
            cur_cmd       <= CMD_START;
            step          <= '0;
            rd_idx        <= '0;
            tx_idx        <= '0;
            i2c_cmd_valid <= 1'b0;
            i2c_wdata     <= '0;
            tx_valid      <= 1'b0;
            tx_data       <= '0;
            init_done     <= 1'b0;
            err_nack      <= 1'b0;
            overrun       <= 1'b0;
            sample_count  <= '0;
            for (int i = 0; i < MAX_BURST; i++) begin
                burst_buf[i] <= '0;
            end
        end else begin
            if (tick && enable && (state != IDLE)) begin
                overrun <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (tick && enable) begin
                        step   <= '0;
                        rd_idx <= '0;
                        state  <= init_done ? RD_ISSUE : INIT_ISSUE;
                    end
                end
                // Load the command one cycle, then hold it until accepted
                INIT_ISSUE, RD_ISSUE, ABORT_STOP: begin
                    if (!i2c_cmd_valid) begin
                        i2c_cmd_valid <= 1'b1;
                        cur_cmd       <= nxt_cmd;
                        i2c_wdata     <= nxt_wdata;
                    end else if (i2c_cmd_ready) begin
                        i2c_cmd_valid <= 1'b0;
                        state <= (state == INIT_ISSUE) ? INIT_WAIT :
                                 (state == RD_ISSUE)   ? RD_WAIT   : ABORT_WAIT;
                    end
                end
                INIT_WAIT, RD_WAIT: begin
                    if (i2c_rsp_valid) begin
                        if ((cur_cmd == CMD_WRITE) && i2c_rsp_nack) begin
                            err_nack <= 1'b1;
                            state    <= ABORT_STOP;
                        end else if (cur_cmd == CMD_STOP) begin
                            if (state == INIT_WAIT) begin
                                init_done <= 1'b1;
                                state     <= IDLE;
                            end else begin
                                tx_valid <= 1'b1;
                                tx_data  <= FRAME_HDR;
                                tx_idx   <= '0;
                                state    <= SEND;
                            end
                        end else begin
                            if (is_read_cmd(cur_cmd)) begin
                                burst_buf[rd_idx] <= i2c_rsp_data;
                                rd_idx            <= rd_idx + 4'd1;
                            end
                            step  <= step + 5'd1;
                            state <= (state == INIT_WAIT) ? INIT_ISSUE : RD_ISSUE;
                        end
                    end
                end
                ABORT_WAIT: begin
                    if (i2c_rsp_valid) begin
                        state <= IDLE;
                    end
                end
                SEND: begin
                    if (tx_ready) begin
                        if (tx_idx == LAST_BYTE) begin
                            tx_valid     <= 1'b0;
                            sample_count <= sample_count + 16'd1;
                            state        <= IDLE;
                        end else begin
                            tx_data <= burst_buf[tx_idx[3:0]];
                            tx_idx  <= tx_idx + 5'd1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/mpu_sample_sequencer.md
Name: mpu_sample_sequencer

Overview:
- Periodic sequencer for the MPU6050 accelerometer path. Sits between the byte-level I2C master (SCL/SDA engine) and the UART transmitter inside design_1.
- After reset it wakes the sensor by writing PWR_MGMT_1. Every SAMPLE_PERIOD cycles it burst-reads BURST_LEN bytes starting at START_REG, then streams one framed packet to the UART.

Parameters:
- SLAVE_ADDR, 7'h68, 7-bit I2C address of the MPU6050.
- PWR_REG, 8'h6B, register written once during the wake-up sequence.
- PWR_VAL, 8'h00, value written to PWR_REG.
- START_REG, 8'h3B, first register of the burst read.
- BURST_LEN, 6, bytes per burst; legal range 1..16.
- SAMPLE_PERIOD, 2500000, dev_clk cycles between sample ticks (100 ms at 25 MHz).
- FRAME_HDR, 8'hA5, header byte sent before each packet.

Ports:
- dev_clk  in  1  system clock, 25 MHz
- rst  in  1  asynchronous, active-high reset
- enable  in  1  when low, ticks are suppressed; any sequence in progress completes
- i2c_cmd_valid  out  1  command to the I2C master is valid
- i2c_cmd_ready  in  1  I2C master accepts the command
- i2c_cmd  out  3  0=START (repeated START when the bus is already held), 1=WRITE, 2=READ_ACK, 3=READ_NACK, 4=STOP
- i2c_wdata  out  8  byte for WRITE
- i2c_rsp_valid  in  1  one-cycle pulse; exactly one per accepted command, on completion
- i2c_rsp_data  in  8  byte read (READ_* only)
- i2c_rsp_nack  in  1  slave NACKed the WRITE (qualified by rsp_valid)
- tx_valid  out  1  UART byte valid
- tx_data  out  8  UART byte
- tx_ready  in  1  UART accepts the byte
- init_done  out  1  wake-up write acknowledged
- err_nack  out  1  sticky; cleared only by rst
- overrun  out  1  sticky; a tick arrived while not IDLE
- sample_count  out  16  completed packets; wraps at 16'hFFFF->0

Behaviour:
- Reset values: all outputs 0, i2c_cmd=0, i2c_wdata=0, tx_data=0, state=INIT_ISSUE, period counter=0.
- Period counter:
  - Free-runs 0..SAMPLE_PERIOD-1 and produces a one-cycle tick at the terminal count.
  - A tick only takes effect when enable=1 and state=IDLE.
  - A tick in any other state with enable=1 sets overrun and is otherwise discarded; it is not queued.
- Command handshake:
  - cmd_valid is held with cmd/wdata stable until a cycle where cmd_valid&&cmd_ready.
  - The FSM then waits for rsp_valid before issuing the next command. One command is outstanding at most.
  - cmd_valid drops in the cycle after acceptance.
- Command lists:
  - INIT list: START; WRITE {SLAVE_ADDR,0}; WRITE PWR_REG; WRITE PWR_VAL; STOP.
  - READ list: START; WRITE {SLAVE_ADDR,0}; WRITE START_REG; START; WRITE {SLAVE_ADDR,1}; (BURST_LEN-1)x READ_ACK; READ_NACK; STOP.
  - When BURST_LEN=1, the READ list has only READ_NACK, with no READ_ACK.
- FSM states: INIT_ISSUE, INIT_WAIT, IDLE, RD_ISSUE, RD_WAIT, ABORT_STOP, ABORT_WAIT, SEND.
  - A step index (5 bits) selects the current entry of the command list.
  - INIT completes on the STOP rsp: init_done=1, then IDLE.
  - From IDLE, a tick goes to RD_ISSUE if init_done, otherwise to INIT_ISSUE (retry of the wake-up).
  - READ_* rsp data is stored into buf[k], k=0..BURST_LEN-1, in arrival order.
  - The READ list completes on the STOP rsp, then SEND.
- NACK handling: rsp_nack=1 on any WRITE sets err_nack, goes to ABORT_STOP, issues STOP, waits for its rsp, then IDLE. The buffer is discarded and sample_count is unchanged. The rsp_nack value is ignored for START, STOP and READ_*.
- SEND:
  - Emits FRAME_HDR, then buf[0]..buf[BURST_LEN-1] on the tx valid/ready handshake. tx_data is held stable while tx_valid=1 && !tx_ready.
  - Back-to-back bytes are allowed: the next byte is presented in the cycle after acceptance.
  - After the last byte is accepted: sample_count+=1, then IDLE.
- enable deasserted mid-sequence: the sequence runs to IDLE, then waits in IDLE.
- rst mid-operation: asynchronous return to reset values. A partial I2C transfer is not closed; the I2C master is reset on the same rst.

Decomposition:
- Package mpu_seq_pkg holds:
  - the i2c_cmd_t encodings (START/WRITE/READ_ACK/READ_NACK/STOP);
  - the FSM state enum;
  - MPU register constants (PWR_MGMT_1=8'h6B, ACCEL_XOUT_H=8'h3B).
- One sub-module, seq_period_timer: counter plus tick output.
- The FSM, the step decode and the burst buffer stay in mpu_sample_sequencer.

Test Plan:
- Reset, then let an I2C slave model at 0x68 ACK everything -> observed bus writes are D0,6B,00, then STOP; init_done=1; the slave register 0x6B holds 00.
- Slave memory 3B..40 = DE,AD,BE,EF,C0,DE; wait one tick -> UART bytes A5,DE,AD,BE,EF,C0,DE; the last read ends with NACK then STOP; sample_count=1.
- Slave at 0x69 (wrong address) -> NACK on D0, STOP issued, err_nack=1, init_done=0, no UART bytes; the next tick retries INIT.
- tx_ready held low for 10000 cycles during SEND, with SAMPLE_PERIOD=2000 -> tx_data stays A5 and stable; overrun=1; the packet is still complete and in order after release.
- enable=0 for three periods -> no I2C commands issued and sample_count is constant; on re-enable the next tick starts a READ list.
- Assert rst at READ step 7 -> all outputs are 0 within the same cycle; the sequence restarts with the INIT list; sample_count=0.
